// File: rtl/eeprom_spi_ctrl_if.sv
// Command/response bundle between the OPB register decode and the SPI EEPROM sequencer.
// The master side issues command words; the slave side returns completion and status.
interface eeprom_spi_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_word;
  logic        done;
  logic [7:0]  rd_data;
  logic        op_err;
  logic        timeout_err;

  modport master (
    output cmd_valid, cmd_word,
    input  cmd_ready, done, rd_data, op_err, timeout_err
  );

  modport slave (
    input  cmd_valid, cmd_word,
    output cmd_ready, done, rd_data, op_err, timeout_err
  );
endinterface

// File: rtl/eeprom_spi_ctrl.sv
// Expands one 32-bit command word into the 25xx-style SPI frame sequence
// (WREN/WRITE/poll, READ, RDSR) and drives the EEPROM pins in SPI mode 0.
module eeprom_spi_ctrl #(
  parameter int CLK_DIV  = 5,
  parameter int CS_GAP   = 10,
  parameter int POLL_MAX = 20000
) (
  input  logic             SYS_CLK,
  input  logic             RESET_N,
  eeprom_spi_ctrl_if.slave cmd,
  output logic             EEP_CS_N,
  output logic             EEP_SCK,
  output logic             EEP_SI,
  input  logic             EEP_SO
);
  localparam int TMR_W  = $clog2(CLK_DIV + CS_GAP + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);
  localparam logic [TMR_W-1:0]  DIV_LAST = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0]  GAP_LAST = TMR_W'(CS_GAP - 1);
  localparam logic [POLL_W-1:0] POLL_LIM = POLL_W'(POLL_MAX);
  localparam logic [7:0] OP_WRITE = 8'h30;
  localparam logic [7:0] OP_READ  = 8'h00;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_e;
  typedef enum logic [2:0] {FR_WREN, FR_WRITE, FR_READ, FR_RDSR, FR_POLL} frame_e;

  state_e              state_q, state_d;
  frame_e              frame_q, frame_d;
  logic [31:0]         word_q, word_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [2:0]          bit_q, bit_d;
  logic [1:0]          byte_q, byte_d;
  logic [7:0]          tx_q, tx_d;
  logic [7:0]          rx_q, rx_d;
  logic [POLL_W-1:0]   poll_q, poll_d;
  logic                cs_n_q, cs_n_d;
  logic                sck_q, sck_d;
  logic                si_q, si_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic [7:0]          rd_q, rd_d;
  logic                op_err_q, op_err_d;
  logic                to_err_q, to_err_d;
  logic                start_frame;
  frame_e              start_kind;
  logic                finish;

  function automatic logic [7:0] frame_byte(frame_e fr, logic [1:0] idx, logic [23:0] w);
    logic [7:0] b;
    b = 8'h00;
    case (fr)
      FR_WREN:  b = 8'h06;
      FR_WRITE: case (idx)
                  2'd0:    b = 8'h02;
                  2'd1:    b = w[23:16];
                  2'd2:    b = w[15:8];
                  default: b = w[7:0];
                endcase
      FR_READ:  case (idx)
                  2'd0:    b = 8'h03;
                  2'd1:    b = w[23:16];
                  2'd2:    b = w[15:8];
                  default: b = 8'h00;
                endcase
      default:  b = (idx == 2'd0) ? 8'h05 : 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [1:0] frame_last(frame_e fr);
    logic [1:0] n;
    case (fr)
      FR_WREN:           n = 2'd0;
      FR_WRITE, FR_READ: n = 2'd3;
      default:           n = 2'd1;
    endcase
    return n;
  endfunction

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    word_d      = word_q;
    tmr_d       = tmr_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    poll_d      = poll_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    si_d        = si_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    rd_d        = rd_q;
    op_err_d    = op_err_q;
    to_err_d    = to_err_q;
    start_frame = 1'b0;
    start_kind  = frame_q;
    finish      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          word_d   = cmd.cmd_word;
          ready_d  = 1'b0;
          op_err_d = 1'b0;
          to_err_d = 1'b0;
          state_d  = CS_SETUP;
        end
      end
      CS_SETUP: begin
        case (word_q[31:24])
          OP_WRITE: begin start_frame = 1'b1; start_kind = FR_WREN; end
          OP_READ:  begin start_frame = 1'b1; start_kind = FR_READ; end
          OP_RDSR:  begin start_frame = 1'b1; start_kind = FR_RDSR; end
          default:  begin op_err_d = 1'b1; finish = 1'b1; end
        endcase
      end
      SHIFT: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == DIV_LAST) begin
          tmr_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[6:0], EEP_SO};
          end else begin
            // Falling edge: shift out the next bit, or reload for the next byte.
            bit_d = bit_q + 3'd1;
            tx_d  = {tx_q[6:0], 1'b0};
            si_d  = tx_q[6];
            if (bit_q == 3'd7) begin
              if (byte_q == frame_last(frame_q)) begin
                state_d = CS_HOLD;
              end else begin
                byte_d = byte_q + 2'd1;
                tx_d   = frame_byte(frame_q, byte_q + 2'd1, word_q[23:0]);
                si_d   = tx_d[7];
              end
            end
          end
        end
      end
      CS_HOLD: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == DIV_LAST) begin
          tmr_d   = '0;
          cs_n_d  = 1'b1;
          si_d    = 1'b0;
          state_d = GAP;
          if (frame_q == FR_READ || frame_q == FR_RDSR) rd_d = rx_q;
          if (frame_q == FR_POLL && poll_q != POLL_LIM) poll_d = poll_q + 1'b1;
        end
      end
      GAP: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == GAP_LAST) begin
          tmr_d = '0;
          case (frame_q)
            FR_WREN:  begin start_frame = 1'b1; start_kind = FR_WRITE; end
            FR_WRITE: begin poll_d = '0; start_frame = 1'b1; start_kind = FR_POLL; end
            FR_POLL: begin
              // Bit 0 of the status byte is WIP; the poll counter saturates at the limit.
              if (!rx_q[0]) begin
                finish = 1'b1;
              end else if (poll_q == POLL_LIM) begin
                to_err_d = 1'b1;
                finish   = 1'b1;
              end else begin
                start_frame = 1'b1;
                start_kind  = FR_POLL;
              end
            end
            default: finish = 1'b1;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      frame_d = start_kind;
      cs_n_d  = 1'b0;
      sck_d   = 1'b0;
      tx_d    = frame_byte(start_kind, 2'd0, word_q[23:0]);
      si_d    = tx_d[7];
      bit_d   = 3'd0;
      byte_d  = 2'd0;
      tmr_d   = '0;
      state_d = SHIFT;
    end
    if (finish) begin
      done_d  = 1'b1;
      ready_d = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      frame_q  <= FR_WREN;
      word_q   <= '0;
      tmr_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      poll_q   <= '0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      si_q     <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      rd_q     <= '0;
      op_err_q <= 1'b0;
      to_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      word_q   <= word_d;
      tmr_q    <= tmr_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      poll_q   <= poll_d;
      cs_n_q   <= cs_n_d;
      sck_q    <= sck_d;
      si_q     <= si_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      rd_q     <= rd_d;
      op_err_q <= op_err_d;
      to_err_q <= to_err_d;
    end
  end

  assign cmd.cmd_ready   = ready_q;
  assign cmd.done        = done_q;
  assign cmd.rd_data     = rd_q;
  assign cmd.op_err      = op_err_q;
  assign cmd.timeout_err = to_err_q;
  assign EEP_CS_N        = cs_n_q;
  assign EEP_SCK         = sck_q;
  assign EEP_SI          = si_q;
endmodule

// File: tb/tb_eeprom_spi_ctrl.sv
// Bench for eeprom_spi_ctrl: a behavioural 25xx EEPROM plus a pin-timing monitor,
// driven by a table of command vectors and a few hand-written corner sequences.
module tb_eeprom_spi_ctrl;
  localparam int CLK_DIV  = 5;
  localparam int CS_GAP   = 10;
  localparam int POLL_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic cs_n, sck, si, so;
  logic so_model = 1'b0;
  logic so_stuck;
  logic mon_en;
  int   checks = 0;
  int   errors = 0;

  eeprom_spi_ctrl_if bus ();

  eeprom_spi_ctrl #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
    .SYS_CLK (clk),
    .RESET_N (rst_n),
    .cmd     (bus),
    .EEP_CS_N(cs_n),
    .EEP_SCK (sck),
    .EEP_SI  (si),
    .EEP_SO  (so)
  );

  always #5 clk = ~clk;
  assign so = so_stuck ? 1'b1 : so_model;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // EEPROM model state
  logic [7:0] mem [logic [15:0]];
  logic [7:0] fb [$];
  logic [7:0] si_q [$];
  logic [7:0] sh;
  logic       wel = 1'b0;
  int         wip_cnt = 0;
  int         n = 0;
  int         frames = 0;
  int         lo = 0, hi = 0, gap = 1000;
  logic       p_cs = 1'b1, p_sck = 1'b0, p_si = 1'b0;

  function automatic logic [7:0] status();
    return {4'b0000, 2'b11, wel, (wip_cnt != 0)};
  endfunction

  function automatic logic [7:0] resp(int bi);
    logic [15:0] a;
    if (fb.size() >= 3 && fb[0] == 8'h03 && bi == 3) begin
      a = {fb[1], fb[2]};
      return mem.exists(a) ? mem[a] : 8'hFF;
    end
    if (fb.size() >= 1 && fb[0] == 8'h05 && bi == 1) return status();
    return 8'h00;
  endfunction

  always @(negedge clk) begin
    logic c, k, d;
    logic [7:0] r;
    c = cs_n; k = sck; d = si;
    if (p_cs && !c) begin
      frames++;
      n = 0; fb.delete();
      r = resp(0); so_model = r[7];
      if (mon_en) chk("cs_gap_min", (gap >= CS_GAP), 1);
      lo = 1; hi = 0;
    end else if (!p_cs && c) begin
      if (mon_en) chk("cs_hold_len", lo, CLK_DIV);
      if (fb.size() >= 1) begin
        if (fb[0] == 8'h06) wel = 1'b1;
        else if (fb[0] == 8'h02 && fb.size() >= 4 && wel) begin
          mem[{fb[1], fb[2]}] = fb[3];
          wip_cnt = 2;
          wel = 1'b0;
        end else if (fb[0] == 8'h05 && fb.size() >= 2 && wip_cnt > 0) wip_cnt--;
      end
      gap = 1;
    end else if (c) begin
      if (gap < 1000) gap++;
      if (mon_en) chk("idle_sck_si", {k, d}, 2'b00);
    end else begin
      if (!p_sck && k) begin
        if (mon_en) chk("sck_low_len", lo, CLK_DIV);
        if (mon_en) chk("si_stable", d, p_si);
        hi = 1;
        sh = {sh[6:0], d};
        n++;
        if (n % 8 == 0) begin fb.push_back(sh); si_q.push_back(sh); end
      end else if (p_sck && !k) begin
        if (mon_en) chk("sck_high_len", hi, CLK_DIV);
        lo = 1;
        r = resp(n / 8);
        so_model = r[7 - (n % 8)];
      end else if (k) hi++;
      else lo++;
    end
    p_cs = c; p_sck = k; p_si = d;
  end

  typedef struct {
    logic [31:0] word;
    bit          stuck;
    int          exp_frames;
    int          nchk;
    logic [39:0] exp_bytes;
    logic [7:0]  exp_rd;
    bit          exp_op;
    bit          exp_to;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int ndone, cyc;
    logic [39:0] act;
    vecs[0] = '{32'h3000005A, 1'b0, 5, 5, 40'h060200005A, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{32'h00000000, 1'b0, 1, 4, 40'h0003000000, 8'h5A, 1'b0, 1'b0};
    vecs[2] = '{32'h301234A5, 1'b0, 5, 5, 40'h06021234A5, 8'h5A, 1'b0, 1'b0};
    vecs[3] = '{32'h00123400, 1'b0, 1, 4, 40'h0003123400, 8'hA5, 1'b0, 1'b0};
    vecs[4] = '{32'h05000000, 1'b0, 1, 2, 40'h0000000500, 8'h0C, 1'b0, 1'b0};
    vecs[5] = '{32'h12345678, 1'b0, 0, 0, 40'h0000000000, 8'h0C, 1'b1, 1'b0};
    vecs[6] = '{32'h00000000, 1'b0, 1, 4, 40'h0003000000, 8'h5A, 1'b0, 1'b0};
    vecs[7] = '{32'h30077733, 1'b1, 6, 5, 40'h0602077733, 8'h5A, 1'b0, 1'b1};
    vecs[8] = '{32'h05000000, 1'b0, 1, 2, 40'h0000000500, 8'h0C, 1'b0, 1'b0};
    vecs[9] = '{32'h00077700, 1'b0, 1, 4, 40'h0003077700, 8'h33, 1'b0, 1'b0};

    rst_n = 1'b0; mon_en = 1'b0; so_stuck = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_word = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sck_si", {sck, si}, 2'b00);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    chk("rst_flags", {bus.done, bus.op_err, bus.timeout_err}, 3'b000);
    rst_n = 1'b1; mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // Unsupported op: done/op_err one edge after the accept edge, no SPI activity.
    frames = 0;
    bus.cmd_valid = 1'b1; bus.cmd_word = 32'h7F000000;
    @(posedge clk); #1; bus.cmd_valid = 1'b0;
    chk("badop_accept_ready", bus.cmd_ready, 0);
    chk("badop_accept_done", bus.done, 0);
    @(posedge clk); #1;
    chk("badop_done", bus.done, 1);
    chk("badop_op_err", bus.op_err, 1);
    chk("badop_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;
    chk("badop_done_pulse", bus.done, 0);
    chk("badop_sticky", bus.op_err, 1);
    chk("badop_no_frames", frames, 0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      so_stuck = vecs[i].stuck;
      frames = 0; si_q.delete();
      bus.cmd_valid = 1'b1; bus.cmd_word = vecs[i].word;
      @(posedge clk); #1; bus.cmd_valid = 1'b0;
      chk($sformatf("v%0d_accept", i), {bus.cmd_ready, bus.op_err, bus.timeout_err, bus.done}, 4'b0000);
      ndone = 0; cyc = 0;
      while (ndone == 0 && cyc < 5000) begin
        @(negedge clk); cyc++;
        if (bus.done === 1'b1) ndone++;
      end
      chk($sformatf("v%0d_done_seen", i), ndone, 1);
      chk($sformatf("v%0d_ready", i), bus.cmd_ready, 1);
      chk($sformatf("v%0d_rd_data", i), bus.rd_data, vecs[i].exp_rd);
      chk($sformatf("v%0d_op_err", i), bus.op_err, vecs[i].exp_op);
      chk($sformatf("v%0d_timeout_err", i), bus.timeout_err, vecs[i].exp_to);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), bus.done, 0);
      chk($sformatf("v%0d_frames", i), frames, vecs[i].exp_frames);
      act = '0;
      for (int k = 0; k < vecs[i].nchk; k++)
        act = {act[31:0], (k < si_q.size()) ? si_q[k] : 8'hEE};
      chk($sformatf("v%0d_si_bytes", i), act, vecs[i].exp_bytes);
      so_stuck = 1'b0;
    end
    chk("mem_0000", mem.exists(16'h0000) ? mem[16'h0000] : 8'hFF, 8'h5A);
    chk("mem_1234", mem.exists(16'h1234) ? mem[16'h1234] : 8'hFF, 8'hA5);

    // Reset in the middle of a READ frame.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_word = 32'h00000000;
    @(posedge clk); #1; bus.cmd_valid = 1'b0;
    cyc = 0;
    while (cs_n !== 1'b0 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("midrst_cs_low", cs_n, 0);
    repeat (100) @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_cs_n", cs_n, 1);
    chk("midrst_sck", sck, 0);
    chk("midrst_ready", bus.cmd_ready, 1);
    chk("midrst_rd_data", bus.rd_data, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_cs_idle", cs_n, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
